// File: rtl/mem_io_unit.sv
// mem_io_unit: data-side RAM plus memory-mapped I/O (screen, chars, number,
// LFSR, controller). Loads are combinational; all state updates on posedge clk.
module mem_io_unit #(
   parameter int RAM_DEPTH = 240,
   parameter int CHARS     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           mem_addr,
   input  logic [7:0]           store_bus,
   input  logic                 mem_we,
   input  logic                 mem_re,
   output logic [7:0]           load_bus,
   input  logic [7:0]           ctrl_in,
   input  logic [4:0]           scr_x,
   input  logic [4:0]           scr_y,
   output logic                 scr_pixel,
   output logic [5*CHARS-1:0]   chars_out,
   output logic [7:0]           num_out,
   output logic                 num_valid,
   output logic                 num_signed
);

   localparam logic [7:0] RAM_TOP = 8'(RAM_DEPTH);
   localparam int         CPTR_W  = (CHARS > 1) ? $clog2(CHARS) : 1;
   localparam logic [CPTR_W-1:0] CPTR_LAST = CPTR_W'(CHARS - 1);

   localparam logic [7:0] A_PIX_X    = 8'd240;
   localparam logic [7:0] A_PIX_Y    = 8'd241;
   localparam logic [7:0] A_PIX_SET  = 8'd242;
   localparam logic [7:0] A_PIX_CLR  = 8'd243;
   localparam logic [7:0] A_PIX_RD   = 8'd244;
   localparam logic [7:0] A_FLIP     = 8'd245;
   localparam logic [7:0] A_PEND_CLR = 8'd246;
   localparam logic [7:0] A_CHAR_WR  = 8'd247;
   localparam logic [7:0] A_CHAR_SHW = 8'd248;
   localparam logic [7:0] A_CHAR_CLR = 8'd249;
   localparam logic [7:0] A_NUM_WR   = 8'd250;
   localparam logic [7:0] A_NUM_OFF  = 8'd251;
   localparam logic [7:0] A_NUM_SGN  = 8'd252;
   localparam logic [7:0] A_NUM_USG  = 8'd253;
   localparam logic [7:0] A_LFSR     = 8'd254;
   localparam logic [7:0] A_CTRL     = 8'd255;

   logic [7:0]          ram_q [RAM_DEPTH];
   logic                ram_hit;

   logic [4:0]          pix_x_q, pix_y_q;
   logic [1023:0]       pend_q, disp_q;
   logic [4:0]          cbuf_q [CHARS];
   logic [CPTR_W-1:0]   cptr_q;
   logic [5*CHARS-1:0]  chars_q;
   logic [7:0]          num_q;
   logic                num_valid_q, num_signed_q;
   logic [7:0]          lfsr_q, lfsr_d;
   logic [7:0]          ctrl_q;
   logic [9:0]          pix_idx;

   assign ram_hit = (mem_addr < RAM_TOP);
   assign pix_idx = {pix_y_q, pix_x_q};
   assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // RAM contents survive reset; a store coincident with rst is dropped.
   always_ff @(posedge clk) begin
      if (!rst && mem_we && ram_hit)
         ram_q[mem_addr] <= store_bus;
   end

   // I/O register state: decode one address per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pend_q       <= '0;
         disp_q       <= '0;
         for (int i = 0; i < CHARS; i++) cbuf_q[i] <= '0;
         cptr_q       <= '0;
         chars_q      <= '0;
         num_q        <= '0;
         num_valid_q  <= 1'b0;
         num_signed_q <= 1'b0;
         lfsr_q       <= 8'h01;
         ctrl_q       <= '0;
      end else begin
         ctrl_q <= ctrl_in;
         if (mem_re && mem_addr == A_LFSR)
            lfsr_q <= lfsr_d;
         if (mem_we) begin
            case (mem_addr)
               A_PIX_X:    pix_x_q <= store_bus[4:0];
               A_PIX_Y:    pix_y_q <= store_bus[4:0];
               A_PIX_SET:  pend_q[pix_idx] <= 1'b1;
               A_PIX_CLR:  pend_q[pix_idx] <= 1'b0;
               A_FLIP:     disp_q <= pend_q;
               A_PEND_CLR: pend_q <= '0;
               A_CHAR_WR: begin
                  cbuf_q[cptr_q] <= store_bus[4:0];
                  cptr_q <= (cptr_q == CPTR_LAST) ? '0 : cptr_q + 1'b1;
               end
               A_CHAR_SHW: begin
                  for (int i = 0; i < CHARS; i++) chars_q[5*i +: 5] <= cbuf_q[i];
               end
               A_CHAR_CLR: begin
                  for (int i = 0; i < CHARS; i++) cbuf_q[i] <= '0;
                  cptr_q <= '0;
               end
               A_NUM_WR: begin
                  num_q       <= store_bus;
                  num_valid_q <= 1'b1;
               end
               A_NUM_OFF:  num_valid_q  <= 1'b0;
               A_NUM_SGN:  num_signed_q <= 1'b1;
               A_NUM_USG:  num_signed_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   // Combinational load path; write-only and strobe ports read as zero.
   always_comb begin
      load_bus = 8'h00;
      if (ram_hit) begin
         load_bus = ram_q[mem_addr];
      end else begin
         case (mem_addr)
            A_PIX_RD: load_bus = {7'b0, pend_q[pix_idx]};
            A_LFSR:   load_bus = lfsr_q;
            A_CTRL:   load_bus = ctrl_q;
            default:  load_bus = 8'h00;
         endcase
      end
   end

   assign scr_pixel  = disp_q[{scr_y, scr_x}];
   assign chars_out  = chars_q;
   assign num_out    = num_q;
   assign num_valid  = num_valid_q;
   assign num_signed = num_signed_q;

endmodule
